stochastic_network_seq: RTL and testbench
=========================================

STOCHASTIC_NETWORK_SEQ -- requirements
Module: stochastic_network_seq

Interface
REQ-001 Parameters SHALL be: INPUT_SIZE 2, fan-in of layer 1; HIDDEN_SIZE 4, layer-1 neuron count; OUTPUT_SIZE 1, layer-2 neuron count; SEED 25, base generator seed; STREAM_LEN 256, counted cycles per evaluation; WARMUP 4, discarded cycles before counting.
REQ-002 One clock; reset is asynchronous and active-low; ports clk and n_rst.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- n_rst  in  1  async active-low reset
- start  in  1  evaluation request
- busy  out  1  high outside IDLE
- net_in  in  INPUT_SIZE x 8  input probabilities, value/256
- bypass  in  1  sampled at start; 1 routes generated input stream (j mod INPUT_SIZE) to counter j
- cfg_we  in  1  weight/bias write strobe
- cfg_layer  in  1  0 = layer 1, 1 = layer 2
- cfg_row, cfg_col  in  8 each  neuron index, fan-in index; cfg_col equal to fan-in selects the bias
- cfg_data  in  8  weight/bias value
- out_valid  out  1  results available
- out_ready  in  1  results consumed
- net_out  out  OUTPUT_SIZE x $clog2(STREAM_LEN+1)  ones count per output

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-005 IDLE->LOAD on start; start outside IDLE SHALL be ignored.
REQ-006 LOAD SHALL last 1 cycle: latch net_in and bypass; reseed all generators and layer randomness to SEED-derived constants; clear counters.
REQ-007 RUN SHALL last WARMUP+STREAM_LEN cycles; counters increment only during the last STREAM_LEN cycles when the output bit is 1.
REQ-008 With start accepted at edge T, out_valid SHALL rise at edge T+2+WARMUP+STREAM_LEN.
REQ-009 DONE SHALL hold out_valid=1 and net_out stable until out_valid&&out_ready, then go to IDLE with out_valid=0.
REQ-010 net_out SHALL retain the last result in IDLE until the next LOAD clears it.
REQ-011 Weight registers SHALL be 8-bit unsigned: w1 HIDDEN_SIZE x INPUT_SIZE, b1 HIDDEN_SIZE, w2 OUTPUT_SIZE x HIDDEN_SIZE, b2 OUTPUT_SIZE.
REQ-012 cfg_we SHALL take effect the next cycle, only in IDLE; writes in other states or with out-of-range row/col SHALL be dropped silently.
REQ-013 Identical weights, inputs and bypass SHALL give bit-identical net_out on every evaluation.
REQ-014 Counter width SHALL hold STREAM_LEN without wrap.
REQ-015 start and cfg_we in the same IDLE cycle: the write SHALL complete and the evaluation SHALL use the new value.

Reset
REQ-016 n_rst low SHALL asynchronously force IDLE, busy=0, out_valid=0, net_out=0, all weights/biases=0 and counters=0, including mid-RUN; no result from an aborted run SHALL appear.

Structure
REQ-017 network_pkg SHALL hold WEIGHT_W=8, the state enum and the cfg_layer encoding.
REQ-018 The datapath SHALL reuse existing generator16 and layer; the new sub-module stream_counter SHALL implement the per-output windowed ones counter with clear/enable.

Verification
REQ-019 Bypass, net_in={0,0}, STREAM_LEN=256 -> net_out[0]=0; out_valid at T+262.
REQ-020 Bypass, net_in[0]=128 -> net_out[0] in 104..152; an immediate repeat gives the identical value.
REQ-021 cfg_we during RUN with data 200 -> dropped; readback via identical rerun unchanged; same write in IDLE changes the result.
REQ-022 out_ready held low 10 cycles in DONE -> out_valid and net_out stable; start pulses ignored; out_ready high -> IDLE next cycle.
REQ-023 n_rst asserted mid-RUN (cycle 100) -> busy and out_valid 0 immediately, weights 0; fresh start then completes normally.
REQ-024 start and cfg_we same cycle (b2=255) -> result matches a run with b2 preloaded to 255.

Source files
------------

// File: rtl/network_pkg.sv
// Shared types and constants for the stochastic two-layer network.
package network_pkg;
    localparam int WEIGHT_W = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
    typedef enum logic {CFG_L1 = 1'b0, CFG_L2 = 1'b1} cfg_layer_e;

    // Derive a distinct, never-zero LFSR seed for generator number idx.
    function automatic logic [15:0] mix_seed(input logic [15:0] base, input int idx);
        logic [15:0] s;
        s = base ^ (16'(idx) * 16'h9E37) ^ 16'h5A5A;
        return (s == 16'h0) ? 16'h0001 : s;
    endfunction
endpackage

// File: rtl/stochastic_network_seq_units.sv
// Building blocks: LFSR bitstream generator, stochastic OR-neuron layer,
// windowed ones counter.
module generator16 import network_pkg::*; #(
    parameter logic [15:0] SEED_VAL = 16'h0001
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                reseed,
    input  logic                en,
    input  logic [WEIGHT_W-1:0] prob,
    output logic                bit_o
);
    logic [15:0] lfsr_q;

    // Maximal-length x^16+x^14+x^13+x^11+1; bit is 1 with probability prob/256.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)      lfsr_q <= SEED_VAL;
        else if (reseed) lfsr_q <= SEED_VAL;
        else if (en)     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign bit_o = lfsr_q[7:0] < prob;
endmodule

module layer import network_pkg::*; #(
    parameter int          N_IN      = 2,
    parameter int          N_OUT     = 4,
    parameter logic [15:0] SEED_BASE = 16'h0001
) (
    input  logic                                   clk,
    input  logic                                   n_rst,
    input  logic                                   reseed,
    input  logic                                   en,
    input  logic [N_IN-1:0]                        in_bits,
    input  logic [N_OUT-1:0][N_IN-1:0][WEIGHT_W-1:0] w,
    input  logic [N_OUT-1:0][WEIGHT_W-1:0]         b,
    output logic [N_OUT-1:0]                       out_bits
);
    // Neuron = OR of (input AND weight stream) terms plus a bias stream.
    for (genvar n = 0; n < N_OUT; n++) begin : g_neu
        logic [N_IN:0] term;
        for (genvar i = 0; i < N_IN; i++) begin : g_in
            logic wbit;
            generator16 #(.SEED_VAL(mix_seed(SEED_BASE, n * (N_IN + 1) + i))) u_w (
                .clk(clk), .n_rst(n_rst), .reseed(reseed), .en(en),
                .prob(w[n][i]), .bit_o(wbit)
            );
            assign term[i] = in_bits[i] & wbit;
        end
        generator16 #(.SEED_VAL(mix_seed(SEED_BASE, n * (N_IN + 1) + N_IN))) u_b (
            .clk(clk), .n_rst(n_rst), .reseed(reseed), .en(en),
            .prob(b[n]), .bit_o(term[N_IN])
        );
        assign out_bits[n] = |term;
    end
endmodule

module stream_counter #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clr,
    input  logic          en,
    input  logic          bit_i,
    output logic [CW-1:0] count_o
);
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)             cnt_q <= '0;
        else if (clr)           cnt_q <= '0;
        else if (en && bit_i)   cnt_q <= cnt_q + 1'b1;
    end

    assign count_o = cnt_q;
endmodule

// File: rtl/stochastic_network_seq.sv
// Sequenced stochastic 2-layer network: configure weights in IDLE, then
// each start runs a reseeded, fixed-length bitstream evaluation.
module stochastic_network_seq import network_pkg::*; #(
    parameter int INPUT_SIZE  = 2,
    parameter int HIDDEN_SIZE = 4,
    parameter int OUTPUT_SIZE = 1,
    parameter int SEED        = 25,
    parameter int STREAM_LEN  = 256,
    parameter int WARMUP      = 4,
    localparam int CW         = $clog2(STREAM_LEN + 1)
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic                                  start,
    output logic                                  busy,
    input  logic [INPUT_SIZE-1:0][WEIGHT_W-1:0]   net_in,
    input  logic                                  bypass,
    input  logic                                  cfg_we,
    input  logic                                  cfg_layer,
    input  logic [7:0]                            cfg_row,
    input  logic [7:0]                            cfg_col,
    input  logic [WEIGHT_W-1:0]                   cfg_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUTPUT_SIZE-1:0][CW-1:0]        net_out
);
    localparam int RUN_LEN = WARMUP + STREAM_LEN;
    localparam int RCW     = $clog2(RUN_LEN + 1);

    state_e                                        state_q;
    logic                                          out_valid_q, bypass_q;
    logic [RCW-1:0]                                rcnt_q;
    logic [INPUT_SIZE-1:0][WEIGHT_W-1:0]           in_q;
    logic [HIDDEN_SIZE-1:0][INPUT_SIZE-1:0][WEIGHT_W-1:0]  w1_q;
    logic [HIDDEN_SIZE-1:0][WEIGHT_W-1:0]                  b1_q;
    logic [OUTPUT_SIZE-1:0][HIDDEN_SIZE-1:0][WEIGHT_W-1:0] w2_q;
    logic [OUTPUT_SIZE-1:0][WEIGHT_W-1:0]                  b2_q;
    logic [INPUT_SIZE-1:0]  in_bits;
    logic [HIDDEN_SIZE-1:0] hid_bits;
    logic [OUTPUT_SIZE-1:0] l2_bits;
    logic load, running, cnt_en, wr_ok, wr_l1, wr_l2;

    assign load      = state_q == LOAD;
    assign running   = state_q == RUN;
    assign cnt_en    = running && (rcnt_q >= RCW'(WARMUP));
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;

    // out_valid rises one cycle after entering DONE, after the last count lands.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            rcnt_q      <= '0;
            in_q        <= '0;
            bypass_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD;
                LOAD: begin
                    in_q     <= net_in;
                    bypass_q <= bypass;
                    rcnt_q   <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    if (rcnt_q == RCW'(RUN_LEN - 1)) state_q <= DONE;
                    else                             rcnt_q  <= rcnt_q + 1'b1;
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ok = cfg_we && (state_q == IDLE);
    assign wr_l1 = wr_ok && (cfg_layer == CFG_L1);
    assign wr_l2 = wr_ok && (cfg_layer == CFG_L2);

    // Decode by exhaustive match so out-of-range row/col can never alias.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w1_q <= '0;
            b1_q <= '0;
            w2_q <= '0;
            b2_q <= '0;
        end else begin
            for (int r = 0; r < HIDDEN_SIZE; r++) begin
                for (int c = 0; c < INPUT_SIZE; c++)
                    if (wr_l1 && cfg_row == 8'(r) && cfg_col == 8'(c)) w1_q[r][c] <= cfg_data;
                if (wr_l1 && cfg_row == 8'(r) && cfg_col == 8'(INPUT_SIZE)) b1_q[r] <= cfg_data;
            end
            for (int r = 0; r < OUTPUT_SIZE; r++) begin
                for (int c = 0; c < HIDDEN_SIZE; c++)
                    if (wr_l2 && cfg_row == 8'(r) && cfg_col == 8'(c)) w2_q[r][c] <= cfg_data;
                if (wr_l2 && cfg_row == 8'(r) && cfg_col == 8'(HIDDEN_SIZE)) b2_q[r] <= cfg_data;
            end
        end
    end

    for (genvar j = 0; j < INPUT_SIZE; j++) begin : g_in
        generator16 #(.SEED_VAL(mix_seed(16'(SEED), j))) u_gen (
            .clk(clk), .n_rst(n_rst), .reseed(load), .en(running),
            .prob(in_q[j]), .bit_o(in_bits[j])
        );
    end

    layer #(.N_IN(INPUT_SIZE), .N_OUT(HIDDEN_SIZE), .SEED_BASE(mix_seed(16'(SEED), 100))) u_l1 (
        .clk(clk), .n_rst(n_rst), .reseed(load), .en(running),
        .in_bits(in_bits), .w(w1_q), .b(b1_q), .out_bits(hid_bits)
    );

    layer #(.N_IN(HIDDEN_SIZE), .N_OUT(OUTPUT_SIZE), .SEED_BASE(mix_seed(16'(SEED), 200))) u_l2 (
        .clk(clk), .n_rst(n_rst), .reseed(load), .en(running),
        .in_bits(hid_bits), .w(w2_q), .b(b2_q), .out_bits(l2_bits)
    );

    for (genvar j = 0; j < OUTPUT_SIZE; j++) begin : g_out
        logic cbit;
        assign cbit = bypass_q ? in_bits[j % INPUT_SIZE] : l2_bits[j];
        stream_counter #(.CW(CW)) u_cnt (
            .clk(clk), .n_rst(n_rst), .clr(load), .en(cnt_en),
            .bit_i(cbit), .count_o(net_out[j])
        );
    end
endmodule

// File: tb/tb_stochastic_network_seq.sv
// Directed bench: exact results where the stream is deterministic, ranges
// for probabilistic ones, and equality across repeated evaluations.
module tb_stochastic_network_seq;
    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            start = 1'b0, bypass = 1'b0, cfg_we = 1'b0, cfg_layer = 1'b0, out_ready = 1'b0;
    logic            busy, out_valid;
    logic [1:0][7:0] net_in = '0;
    logic [7:0]      cfg_row = '0, cfg_col = '0, cfg_data = '0;
    logic [0:0][8:0] net_out;
    int              vectors = 0, miscompares = 0, cyc = 0, t0 = 0;
    logic [8:0]      r1, r2, hold;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stochastic_network_seq dut (
        .clk(clk), .n_rst(n_rst), .start(start), .busy(busy), .net_in(net_in),
        .bypass(bypass), .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_row(cfg_row),
        .cfg_col(cfg_col), .cfg_data(cfg_data), .out_valid(out_valid),
        .out_ready(out_ready), .net_out(net_out)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic launch(input logic byp, input logic [7:0] a, input logic [7:0] b);
        net_in[0] = a; net_in[1] = b; bypass = byp; start = 1'b1;
        tick();
        t0 = cyc; start = 1'b0; cfg_we = 1'b0;
    endtask

    // Bounded wait; a timeout shows up as a latency miscompare.
    task automatic wait_done(output logic [8:0] res);
        int n = 0;
        while (!out_valid && n < 600) begin tick(); n++; end
        chk("latency", cyc - t0, 262);
        res = net_out[0];
    endtask

    task automatic ack();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic cfg(input logic l, input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        cfg_we = 1'b1; cfg_layer = l; cfg_row = r; cfg_col = c; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic eval(input logic byp, input logic [7:0] a, input logic [7:0] b, output logic [8:0] res);
        launch(byp, a, b); wait_done(res); ack();
    endtask

    initial begin
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_out", net_out[0], 0);
        n_rst = 1'b1;
        tick();

        // Zero-probability input through bypass
        eval(1'b1, 8'd0, 8'd0, r1);
        chk("byp_zero", r1, 0);
        // Counter 0 must see input 0, not input 1
        eval(1'b1, 8'd0, 8'd255, r1);
        chk("byp_route", r1, 0);
        // Half probability, then identical repeat
        eval(1'b1, 8'd128, 8'd0, r1);
        chk_rng("byp_half", r1, 104, 152);
        eval(1'b1, 8'd128, 8'd0, r2);
        chk("byp_repeat", r2, r1);

        // Out-of-range row must not alias onto b2
        cfg(1'b1, 8'd1, 8'd4, 8'd255);
        eval(1'b0, 8'd0, 8'd0, r1);
        chk("oor_drop", r1, 0);

        // Write during RUN is dropped
        launch(1'b0, 8'd0, 8'd0);
        repeat (50) tick();
        cfg(1'b1, 8'd0, 8'd4, 8'd200);
        wait_done(r1); ack();
        chk("run_wr_drop", r1, 0);
        eval(1'b0, 8'd0, 8'd0, r2);
        chk("rerun_same", r2, 0);

        // Same write in IDLE; then hold results in DONE
        cfg(1'b1, 8'd0, 8'd4, 8'd200);
        launch(1'b0, 8'd0, 8'd0);
        wait_done(r1);
        chk_rng("b2_200", r1, 170, 230);
        hold = r1;
        for (int i = 0; i < 10; i++) begin
            start = (i % 2 == 0);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_out", net_out[0], hold);
            chk("hold_busy", busy, 1);
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ack_valid", out_valid, 0);
        chk("ack_busy", busy, 0);
        tick();
        chk("retain", net_out[0], hold);

        // Reset mid-RUN
        launch(1'b0, 8'd0, 8'd0);
        repeat (99) tick();
        n_rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_out", net_out[0], 0);
        tick();
        n_rst = 1'b1;
        tick();
        eval(1'b0, 8'd0, 8'd0, r1);
        chk("post_rst_w0", r1, 0);

        // start together with a b2 write, versus b2 preloaded
        cfg_we = 1'b1; cfg_layer = 1'b1; cfg_row = 8'd0; cfg_col = 8'd4; cfg_data = 8'd255;
        launch(1'b0, 8'd0, 8'd0);
        wait_done(r1); ack();
        chk_rng("same_cyc_wr", r1, 240, 256);
        eval(1'b0, 8'd0, 8'd0, r2);
        chk("same_vs_pre", r2, r1);

        // Full path through layer 1: b1[0]=255 feeding w2[0][0]=255
        cfg(1'b1, 8'd0, 8'd4, 8'd0);
        cfg(1'b0, 8'd0, 8'd2, 8'd255);
        cfg(1'b1, 8'd0, 8'd0, 8'd255);
        eval(1'b0, 8'd0, 8'd0, r1);
        chk_rng("l1_path", r1, 225, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
